phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Generates the multi-phase instruction cycle for the processor datapath: a registered phase counter plus one-hot phase enables for the fetch/decode/execute/memory/writeback stages.
- Implements the run/stop/single-step/halt policy driven by the front-panel exec button and the datapath halt flag.
- Sits between the board I/O (clock, reset, exec, step switch) and the datapath phase-gated registers.

Parameters:
- NUM_PHASES, 5, number of phases per instruction (phase 0 .. NUM_PHASES-1)
- PHASE_W, 3, width of phase output; must satisfy 2**PHASE_W >= NUM_PHASES
- SYNC_STAGES, 2, flops in the exec input synchronizer (>= 2)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- exec  in  1  raw pushbutton, asynchronous to clock, already debounced externally
- step_mode  in  1  level: 1 = single-instruction step, 0 = free run
- halt  in  1  datapath halt flag; sampled only at the instruction boundary
- stall  in  1  datapath wait request; freezes the current phase
- phase  out  PHASE_W  current phase index
- phase_en  out  NUM_PHASES  one-hot phase enable for datapath registers
- instr_done  out  1  one-cycle pulse on the last phase of each completed instruction
- running  out  1  high in RUN or STEP
- halted  out  1  high in HALTED

Behaviour:
- Reset (asynchronous): state=IDLE, phase=0, pause_req=0, all synchronizer and edge-history flops=1 (a button held through reset release produces no pulse). Outputs: phase_en=0, instr_done=0, running=0, halted=0.
- Exec edge detection:
  - exec_pulse = sync_out & ~prev (combinational).
  - exec_pulse is high for exactly 1 cycle, SYNC_STAGES clock edges after exec rises.
  - The state change takes effect on the following edge.
- States: IDLE, RUN, STEP, HALTED (2-bit encoding).
- active = (state==RUN or STEP) & ~stall.
  - phase_en = active ? onehot(phase) : 0.
  - last = active & (phase==NUM_PHASES-1).
  - instr_done = last.
- Phase counter: increments when active; wraps to 0 on last. Holds while stall=1 or while not RUN/STEP.
- IDLE:
  - exec_pulse -> STEP if step_mode=1, else RUN.
  - step_mode is sampled only at this transition.
  - phase stays 0.
- RUN:
  - exec_pulse sets pause_req (no immediate effect, so an instruction is never truncated).
  - On last: halt=1 -> HALTED; else pause_req=1 -> IDLE and clear pause_req; else stay in RUN.
- STEP:
  - exec_pulse ignored.
  - On last: halt=1 -> HALTED, else -> IDLE.
  - Exactly one instruction (NUM_PHASES active cycles, excluding stall cycles) per step.
- HALTED:
  - phase_en=0, phase=0, exec_pulse ignored.
  - Only reset exits.
- Simultaneous events:
  - halt together with pause_req at the boundary -> HALTED wins and clears pause_req.
  - stall=1 on the last phase -> no boundary that cycle; halt and pause_req are evaluated when stall drops.
  - exec_pulse on the same cycle as last in RUN -> counts as the pause request for this boundary (go to IDLE).
- halt is ignored outside the last active phase.
- Reset mid-instruction: immediate return to IDLE with phase 0. A partial instruction is discarded; no instr_done is emitted.

Decomposition:
- Shared package proc_pkg:
  - state enum (ST_IDLE, ST_RUN, ST_STEP, ST_HALTED)
  - NUM_PHASES default
  - named phase constants PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_MEM=3, PH_WB=4
- One sub-module: exec_edge_sync (SYNC_STAGES flop chain plus rising-edge pulse, reset value 1), reusable for other panel buttons.

Test Plan:
- Reset then exec rise with step_mode=0 -> running=1 three edges later; phase_en cycles 00001,00010,00100,01000,10000,00001...; instr_done once every 5 cycles.
- RUN, exec pressed when phase=2 -> phase completes 3,4; instr_done=1; state IDLE; phase=0; phase_en=0 thereafter.
- step_mode=1, two exec presses -> exactly 10 phase_en pulses and 2 instr_done pulses total; IDLE between presses.
- RUN, stall=1 for 3 cycles at phase=1 -> phase held at 1, phase_en=0 during stall; then resumes at phase=2; instruction takes 8 cycles.
- Cases for halt:
  - halt=1 at phase=4 -> halted=1, running=0, phase=0; subsequent exec presses have no effect until reset.
  - halt=1 at phase=2 only -> ignored, operation continues.
- Reset asserted at phase=3 while exec held high -> immediate IDLE, phase=0; after release, no exec_pulse until the button is released and pressed again.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the processor control path: sequencer state
// encoding, default phase geometry and the names of the datapath phases.
package proc_pkg;

    // Default phase geometry of one instruction.
    localparam int NUM_PHASES_DEF  = 5;
    localparam int PHASE_W_DEF     = 3;
    localparam int SYNC_STAGES_DEF = 2;

    // Datapath stage that each phase index drives.
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;
    localparam int PH_WB     = 4;

    // Sequencer run state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/phase_sequencer_exec_edge_sync.sv
// Button input conditioner: a SYNC_STAGES flop synchronizer followed by a
// rising-edge detector. Every flop resets to 1, so a button that is already
// held down when reset is released is treated as "old news" and produces no
// pulse until it has been released and pressed again.
module exec_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw input through the synchronizer and remember the last
    // synchronized level for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Single-cycle pulse on a synchronized 0 -> 1 transition.
    always_comb begin
        pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer. Steps the datapath through NUM_PHASES phases
// per instruction with one-hot phase enables, and applies the front-panel
// run / stop / single-step policy plus the datapath halt flag. Run-state
// changes only happen at an instruction boundary (the last, unstalled phase),
// so an instruction is never cut short except by reset.
module phase_sequencer
    import proc_pkg::*;
#(
    parameter int NUM_PHASES  = NUM_PHASES_DEF,
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec,
    input  logic                  step_mode,
    input  logic                  halt,
    input  logic                  stall,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  instr_done,
    output logic                  running,
    output logic                  halted,
    output state_t                state_dbg
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 pause_q, pause_d;
    logic                 exec_pulse;
    logic                 active;
    logic                 last;

    exec_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_exec_sync (
        .clock (clock),
        .reset (reset),
        .din   (exec),
        .pulse (exec_pulse)
    );

    // A phase is "active" when the sequencer is executing and the datapath
    // is not requesting a wait; the boundary is the last active phase.
    always_comb begin
        active = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !stall;
        last   = active && (phase_q == LAST_PHASE);
    end

    // State, phase counter and pending-pause registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pause_q <= pause_d;
        end
    end

    // Next-state, phase advance and pause-request bookkeeping.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pause_d = pause_q;

        if (active) begin
            phase_d = last ? '0 : phase_q + PHASE_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // step_mode only matters at the moment execution starts.
                phase_d = '0;
                pause_d = 1'b0;
                if (exec_pulse) begin
                    state_d = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    // Halt beats a pending pause; a press landing on the
                    // boundary cycle counts for this boundary.
                    pause_d = 1'b0;
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else if (pause_q || exec_pulse) begin
                        state_d = ST_IDLE;
                    end
                end else if (exec_pulse) begin
                    pause_d = 1'b1;
                end
            end
            ST_STEP: begin
                if (last) begin
                    state_d = halt ? ST_HALTED : ST_IDLE;
                end
            end
            ST_HALTED: begin
                phase_d = '0;
                pause_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                pause_d = 1'b0;
            end
        endcase
    end

    // Datapath-facing outputs decoded from the current state and phase.
    always_comb begin
        phase_en = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            phase_en[i] = active && (phase_q == PHASE_W'(i));
        end
        phase      = phase_q;
        instr_done = last;
        running    = (state_q == ST_RUN) || (state_q == ST_STEP);
        halted     = (state_q == ST_HALTED);
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: run, pause, single step, stall, halt
// and reset-with-button-held scenarios, each checked against hand-computed
// values.
module tb_phase_sequencer;
    import proc_pkg::*;

    localparam int NP = 5;
    localparam int PW = 3;

    logic          clock;
    logic          reset;
    logic          exec;
    logic          step_mode;
    logic          halt;
    logic          stall;
    logic [PW-1:0] phase;
    logic [NP-1:0] phase_en;
    logic          instr_done;
    logic          running;
    logic          halted;
    state_t        state_dbg;

    int tests    = 0;
    int failures = 0;

    logic [NP-1:0] exp_q[$];
    logic [NP-1:0] exp_en;
    int            en_cnt;
    int            done_cnt;
    int            cyc;

    phase_sequencer #(
        .NUM_PHASES (NP),
        .PHASE_W    (PW),
        .SYNC_STAGES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .exec      (exec),
        .step_mode (step_mode),
        .halt      (halt),
        .stall     (stall),
        .phase     (phase),
        .phase_en  (phase_en),
        .instr_done(instr_done),
        .running   (running),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    // Clock and run-time guard.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench did not finish");
    end

    // Advance n rising edges, landing 1 time unit after the last edge.
    task automatic step_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a given phase value.
    task automatic wait_phase(input logic [PW-1:0] p, input string tag);
        int n;
        n = 0;
        while (phase !== p && n < 20) begin
            step_clk(1);
            n++;
        end
        check(tag, 32'(phase), 32'(p));
    endtask

    initial begin
        reset     = 1'b1;
        exec      = 1'b0;
        step_mode = 1'b0;
        halt      = 1'b0;
        stall     = 1'b0;
        step_clk(2);

        // Reset values.
        check("rst_phase",      32'(phase),      32'd0);
        check("rst_phase_en",   32'(phase_en),   32'd0);
        check("rst_instr_done", 32'(instr_done), 32'd0);
        check("rst_running",    32'(running),    32'd0);
        check("rst_halted",     32'(halted),     32'd0);
        check("rst_state",      32'(state_dbg),  32'(ST_IDLE));
        reset = 1'b0;
        step_clk(4);

        // Free run: running rises on the third edge after exec.
        exec = 1'b1;
        step_clk(2);
        check("run_not_yet", 32'(running), 32'd0);
        step_clk(1);
        check("run_start", 32'(running), 32'd1);
        check("run_state", 32'(state_dbg), 32'(ST_RUN));
        for (int i = 0; i < 2 * NP; i++) exp_q.push_back(NP'(1 << (i % NP)));
        while (exp_q.size() > 0) begin
            exp_en = exp_q.pop_front();
            check("run_phase_en", 32'(phase_en), 32'(exp_en));
            check("run_instr_done", 32'(instr_done), 32'(exp_en[NP-1]));
            step_clk(1);
        end
        exec = 1'b0;

        // Press at phase 2: its pulse lands on the last phase, instruction completes.
        step_clk(2);
        check("p2_phase_at_press", 32'(phase), 32'(PH_EXEC));
        exec = 1'b1;
        step_clk(1);
        check("p2_phase_mem", 32'(phase), 32'(PH_MEM));
        check("p2_running", 32'(running), 32'd1);
        step_clk(1);
        check("p2_phase_wb", 32'(phase), 32'(PH_WB));
        check("p2_instr_done", 32'(instr_done), 32'd1);
        step_clk(1);
        check("p2_idle_state", 32'(state_dbg), 32'(ST_IDLE));
        check("p2_idle_phase", 32'(phase), 32'd0);
        check("p2_idle_en", 32'(phase_en), 32'd0);
        step_clk(2);
        check("p2_idle_en_hold", 32'(phase_en), 32'd0);
        check("p2_idle_running", 32'(running), 32'd0);
        exec = 1'b0;
        step_clk(4);

        // Pause requested early (pulse at phase 2): held until the boundary.
        exec = 1'b1;
        step_clk(3);
        check("pr_running", 32'(running), 32'd1);
        check("pr_phase0", 32'(phase), 32'd0);
        exec = 1'b0;
        step_clk(5);
        check("pr_second_instr", 32'(phase), 32'd0);
        exec = 1'b1;
        step_clk(2);
        check("pr_pulse_phase", 32'(phase), 32'(PH_EXEC));
        step_clk(1);
        check("pr_not_truncated", 32'(running), 32'd1);
        check("pr_phase_mem", 32'(phase), 32'(PH_MEM));
        step_clk(1);
        check("pr_instr_done", 32'(instr_done), 32'd1);
        step_clk(1);
        check("pr_idle_state", 32'(state_dbg), 32'(ST_IDLE));
        check("pr_idle_phase", 32'(phase), 32'd0);
        exec = 1'b0;
        step_clk(4);

        // Single step: two presses give exactly two instructions.
        step_mode = 1'b1;
        en_cnt    = 0;
        done_cnt  = 0;
        for (int p = 0; p < 2; p++) begin
            exec = 1'b1;
            for (int i = 0; i < 12; i++) begin
                step_clk(1);
                if (i == 3) exec = 1'b0;
                if (p == 1 && i == 5) step_mode = 1'b0;
                if (phase_en != '0) en_cnt++;
                if (instr_done) done_cnt++;
            end
            check("step_idle_between", 32'(state_dbg), 32'(ST_IDLE));
            check("step_running_low", 32'(running), 32'd0);
        end
        check("step_en_pulses", 32'(en_cnt), 32'd10);
        check("step_done_pulses", 32'(done_cnt), 32'd2);
        step_mode = 1'b0;

        // Stall for 3 cycles at phase 1: instruction stretches to 8 cycles.
        exec = 1'b1;
        step_clk(3);
        check("st_run_state", 32'(state_dbg), 32'(ST_RUN));
        check("st_phase0", 32'(phase), 32'd0);
        exec = 1'b0;
        cyc = 1;
        step_clk(1);
        cyc++;
        check("st_phase1", 32'(phase), 32'(PH_DECODE));
        stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("st_hold_phase", 32'(phase), 32'(PH_DECODE));
            check("st_hold_en", 32'(phase_en), 32'd0);
            step_clk(1);
            cyc++;
        end
        stall = 1'b0;
        #1;
        check("st_resume_en", 32'(phase_en), 32'b00010);
        step_clk(1);
        cyc++;
        check("st_resume_phase", 32'(phase), 32'(PH_EXEC));
        while (instr_done !== 1'b1 && cyc < 20) begin
            step_clk(1);
            cyc++;
        end
        check("st_instr_cycles", 32'(cyc), 32'd8);

        // Halt at phase 2 is ignored; halt at phase 4 stops for good.
        step_clk(1);
        wait_phase(PH_EXEC[PW-1:0], "h_wait_p2");
        halt = 1'b1;
        step_clk(1);
        halt = 1'b0;
        check("h_ignored_phase", 32'(phase), 32'(PH_MEM));
        check("h_ignored_running", 32'(running), 32'd1);
        check("h_ignored_halted", 32'(halted), 32'd0);
        step_clk(1);
        check("h_phase_wb", 32'(phase), 32'(PH_WB));
        halt = 1'b1;
        check("h_last_done", 32'(instr_done), 32'd1);
        step_clk(1);
        halt = 1'b0;
        check("h_halted", 32'(halted), 32'd1);
        check("h_running", 32'(running), 32'd0);
        check("h_phase", 32'(phase), 32'd0);
        check("h_phase_en", 32'(phase_en), 32'd0);
        exec = 1'b1;
        step_clk(5);
        exec = 1'b0;
        step_clk(5);
        check("h_exec_ignored", 32'(halted), 32'd1);
        check("h_state", 32'(state_dbg), 32'(ST_HALTED));
        check("h_phase_hold", 32'(phase), 32'd0);

        // Reset leaves HALTED; then reset mid-instruction with exec held.
        reset = 1'b1;
        step_clk(1);
        reset = 1'b0;
        step_clk(4);
        check("r_exit_halted", 32'(halted), 32'd0);
        check("r_exit_state", 32'(state_dbg), 32'(ST_IDLE));
        exec = 1'b1;
        step_clk(3);
        check("r_run", 32'(running), 32'd1);
        wait_phase(PH_MEM[PW-1:0], "r_wait_p3");
        reset = 1'b1;
        #1;
        check("r_async_phase", 32'(phase), 32'd0);
        check("r_async_running", 32'(running), 32'd0);
        check("r_async_en", 32'(phase_en), 32'd0);
        check("r_async_done", 32'(instr_done), 32'd0);
        check("r_async_state", 32'(state_dbg), 32'(ST_IDLE));
        step_clk(2);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step_clk(1);
            check("r_held_no_start", 32'(running), 32'd0);
        end
        exec = 1'b0;
        step_clk(4);
        exec = 1'b1;
        step_clk(2);
        check("r_repress_wait", 32'(running), 32'd0);
        step_clk(1);
        check("r_repress_run", 32'(running), 32'd1);
        exec = 1'b0;
        step_clk(2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
